// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern generator: mode encodings, RGB565 bar
// colours and default 640x480@60 timing.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_GRID  = 2'd3
  } mode_e;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_SYNC_POL  = 0;
  localparam int DEF_CELL_LOG2 = 5;
  localparam int DEF_RGB_W     = 16;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// VGA connector bundle. There is no valid/ready handshake: the generator
// streams one pixel per clock and the sink must accept every cycle.
interface vga_pattern_gen_if #(
  parameter int X_W   = 10,
  parameter int Y_W   = 9,
  parameter int RGB_W = 16
);
  logic [1:0]       mode;
  logic [RGB_W-1:0] solid_rgb;
  logic             hys;
  logic             vys;
  logic             de;
  logic [X_W-1:0]   pix_x;
  logic [Y_W-1:0]   pix_y;
  logic             frame_start;
  logic [RGB_W-1:0] lcd_rgb;

  modport master (
    input  mode, solid_rgb,
    output hys, vys, de, pix_x, pix_y, frame_start, lcd_rgb
  );

  modport slave (
    output mode, solid_rgb,
    input  hys, vys, de, pix_x, pix_y, frame_start, lcd_rgb
  );
endinterface

// File: rtl/vga_timing_core.sv
// Raster counters plus registered sync/de/coordinate/frame-start outputs.
// The *_c outputs describe the current counter state for the pattern stage.
module vga_timing_core
  import vga_pkg::*;
#(
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int SYNC_POL = DEF_SYNC_POL,
  localparam int X_W     = $clog2(H_ACTIVE),
  localparam int Y_W     = $clog2(V_ACTIVE)
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           hys_o,
  output logic           vys_o,
  output logic           de_o,
  output logic [X_W-1:0] pix_x_o,
  output logic [Y_W-1:0] pix_y_o,
  output logic           frame_start_o,
  output logic           de_c_o,
  output logic           h_act_c_o,
  output logic           line_end_c_o,
  output logic           frame_end_c_o,
  output logic [X_W-1:0] x_c_o,
  output logic [Y_W-1:0] y_c_o
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int H_START = H_SYNC + H_BACK;
  localparam int V_START = V_SYNC + V_BACK;
  localparam int H_CW    = $clog2(H_TOTAL);
  localparam int V_CW    = $clog2(V_TOTAL);
  localparam logic SYNC_ON = (SYNC_POL != 0);

  logic [H_CW-1:0] h_cnt_q, h_cnt_d;
  logic [V_CW-1:0] v_cnt_q, v_cnt_d;
  logic            hys_q, vys_q, de_q, fs_q;
  logic [X_W-1:0]  pix_x_q;
  logic [Y_W-1:0]  pix_y_q;

  logic line_end, frame_end, h_act, v_act, de_c, hs_c, vs_c;
  logic [X_W-1:0] x_c;
  logic [Y_W-1:0] y_c;

  // Compare one bit wider so an end-of-region bound equal to 2**CW cannot wrap.
  always_comb begin
    line_end  = (h_cnt_q == H_CW'(H_TOTAL - 1));
    frame_end = line_end && (v_cnt_q == V_CW'(V_TOTAL - 1));
    h_cnt_d   = line_end ? '0 : h_cnt_q + 1'b1;
    v_cnt_d   = v_cnt_q;
    if (line_end) v_cnt_d = frame_end ? '0 : v_cnt_q + 1'b1;
    h_act = ({1'b0, h_cnt_q} >= (H_CW+1)'(H_START)) &&
            ({1'b0, h_cnt_q} <  (H_CW+1)'(H_START + H_ACTIVE));
    v_act = ({1'b0, v_cnt_q} >= (V_CW+1)'(V_START)) &&
            ({1'b0, v_cnt_q} <  (V_CW+1)'(V_START + V_ACTIVE));
    de_c  = h_act && v_act;
    x_c   = de_c ? X_W'(h_cnt_q - H_CW'(H_START)) : '0;
    y_c   = de_c ? Y_W'(v_cnt_q - V_CW'(V_START)) : '0;
    hs_c  = ({1'b0, h_cnt_q} < (H_CW+1)'(H_SYNC));
    vs_c  = ({1'b0, v_cnt_q} < (V_CW+1)'(V_SYNC));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hys_q   <= ~SYNC_ON;
      vys_q   <= ~SYNC_ON;
      de_q    <= 1'b0;
      pix_x_q <= '0;
      pix_y_q <= '0;
      fs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hys_q   <= hs_c ? SYNC_ON : ~SYNC_ON;
      vys_q   <= vs_c ? SYNC_ON : ~SYNC_ON;
      de_q    <= de_c;
      pix_x_q <= x_c;
      pix_y_q <= y_c;
      fs_q    <= (h_cnt_q == '0) && (v_cnt_q == '0);
    end
  end

  assign hys_o         = hys_q;
  assign vys_o         = vys_q;
  assign de_o          = de_q;
  assign pix_x_o       = pix_x_q;
  assign pix_y_o       = pix_y_q;
  assign frame_start_o = fs_q;
  assign de_c_o        = de_c;
  assign h_act_c_o     = h_act;
  assign line_end_c_o  = line_end;
  assign frame_end_c_o = frame_end;
  assign x_c_o         = x_c;
  assign y_c_o         = y_c;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator: solid, colour bars, checker, grid.
// Mode and solid colour are latched on the last clock of a frame only.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int SYNC_POL  = DEF_SYNC_POL,
  parameter int CELL_LOG2 = DEF_CELL_LOG2,
  parameter int RGB_W     = DEF_RGB_W,
  localparam int X_W      = $clog2(H_ACTIVE),
  localparam int Y_W      = $clog2(V_ACTIVE)
) (
  input  logic clk,
  input  logic rst_n,
  vga_pattern_gen_if.master vif
);

  localparam int BAR_W  = H_ACTIVE / 8;
  localparam int BAR_CW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic           de_c, h_act_c, line_end_c, frame_end_c;
  logic [X_W-1:0] x_c;
  logic [Y_W-1:0] y_c;

  vga_timing_core #(
    .H_SYNC  (H_SYNC),   .H_BACK  (H_BACK),
    .H_ACTIVE(H_ACTIVE), .H_FRONT (H_FRONT),
    .V_SYNC  (V_SYNC),   .V_BACK  (V_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT (V_FRONT),
    .SYNC_POL(SYNC_POL)
  ) u_timing (
    .clk          (clk),
    .rst_n        (rst_n),
    .hys_o        (vif.hys),
    .vys_o        (vif.vys),
    .de_o         (vif.de),
    .pix_x_o      (vif.pix_x),
    .pix_y_o      (vif.pix_y),
    .frame_start_o(vif.frame_start),
    .de_c_o       (de_c),
    .h_act_c_o    (h_act_c),
    .line_end_c_o (line_end_c),
    .frame_end_c_o(frame_end_c),
    .x_c_o        (x_c),
    .y_c_o        (y_c)
  );

  mode_e             mode_q, mode_d;
  logic [RGB_W-1:0]  solid_q, solid_d;
  logic [RGB_W-1:0]  lcd_q, lcd_d;
  logic [2:0]        bar_idx_q, bar_idx_d;
  logic [BAR_CW-1:0] bar_px_q, bar_px_d;

  always_comb begin
    mode_d    = mode_q;
    solid_d   = solid_q;
    bar_idx_d = bar_idx_q;
    bar_px_d  = bar_px_q;
    lcd_d     = '0;
    if (frame_end_c) begin
      mode_d  = mode_e'(vif.mode);
      solid_d = vif.solid_rgb;
    end
    // Bar index tracks the current h_cnt; the last bar absorbs any remainder.
    if (line_end_c) begin
      bar_idx_d = '0;
      bar_px_d  = '0;
    end else if (h_act_c) begin
      if (bar_px_q == BAR_CW'(BAR_W - 1)) begin
        bar_px_d = '0;
        if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_px_d = bar_px_q + 1'b1;
      end
    end
    if (de_c) begin
      case (mode_q)
        MODE_SOLID: lcd_d = solid_q;
        MODE_BARS:  lcd_d = RGB_W'(bar_color(bar_idx_q));
        MODE_CHECK: lcd_d = (x_c[CELL_LOG2] ^ y_c[CELL_LOG2]) ? '1 : '0;
        MODE_GRID:  lcd_d = ((x_c[CELL_LOG2-1:0] == '0) || (y_c[CELL_LOG2-1:0] == '0))
                            ? '1 : solid_q;
        default:    lcd_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_SOLID;
      solid_q   <= '0;
      lcd_q     <= '0;
      bar_idx_q <= '0;
      bar_px_q  <= '0;
    end else begin
      mode_q    <= mode_d;
      solid_q   <= solid_d;
      lcd_q     <= lcd_d;
      bar_idx_q <= bar_idx_d;
      bar_px_q  <= bar_px_d;
    end
  end

  assign vif.lcd_rgb = lcd_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a reduced raster; two instances differ only in
// sync polarity. A raster model feeds per-cycle expectations to a queue.
module tb_vga_pattern_gen;

  localparam int TH_SYNC = 4,  TH_BACK = 4, TH_ACT = 84, TH_FRONT = 4;
  localparam int TV_SYNC = 2,  TV_BACK = 3, TV_ACT = 40, TV_FRONT = 2;
  localparam int HT = TH_SYNC + TH_BACK + TH_ACT + TH_FRONT;
  localparam int VT = TV_SYNC + TV_BACK + TV_ACT + TV_FRONT;
  localparam int HS = TH_SYNC + TH_BACK;
  localparam int VS = TV_SYNC + TV_BACK;
  localparam int F  = HT * VT;
  localparam int CELL_LOG2 = 3;
  localparam int CELL = 1 << CELL_LOG2;
  localparam int BAR_W = TH_ACT / 8;
  localparam int X_W = $clog2(TH_ACT);
  localparam int Y_W = $clog2(TV_ACT);
  localparam logic [15:0] BAR_TAB [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                          16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  typedef struct packed {
    logic           hys;
    logic           vys;
    logic           de;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           fs;
    logic [15:0]    rgb;
  } out_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  mode_r  = 2'd0;
  logic [15:0] solid_r = 16'hF800;

  vga_pattern_gen_if #(.X_W(X_W), .Y_W(Y_W), .RGB_W(16)) vif0 ();
  vga_pattern_gen_if #(.X_W(X_W), .Y_W(Y_W), .RGB_W(16)) vif1 ();
  assign vif0.mode = mode_r;
  assign vif0.solid_rgb = solid_r;
  assign vif1.mode = mode_r;
  assign vif1.solid_rgb = solid_r;

  vga_pattern_gen #(
    .H_SYNC(TH_SYNC), .H_BACK(TH_BACK), .H_ACTIVE(TH_ACT), .H_FRONT(TH_FRONT),
    .V_SYNC(TV_SYNC), .V_BACK(TV_BACK), .V_ACTIVE(TV_ACT), .V_FRONT(TV_FRONT),
    .SYNC_POL(0), .CELL_LOG2(CELL_LOG2), .RGB_W(16)
  ) dut0 (.clk(clk), .rst_n(rst_n), .vif(vif0));

  vga_pattern_gen #(
    .H_SYNC(TH_SYNC), .H_BACK(TH_BACK), .H_ACTIVE(TH_ACT), .H_FRONT(TH_FRONT),
    .V_SYNC(TV_SYNC), .V_BACK(TV_BACK), .V_ACTIVE(TV_ACT), .V_FRONT(TV_FRONT),
    .SYNC_POL(1), .CELL_LOG2(CELL_LOG2), .RGB_W(16)
  ) dut1 (.clk(clk), .rst_n(rst_n), .vif(vif1));

  int n_tests = 0;
  int n_fail  = 0;

  // raster model
  out_t exp_q0[$];
  out_t exp_q1[$];
  int          m_h, m_v;
  logic [1:0]  m_mode;
  logic [15:0] m_solid;

  function automatic out_t model_out(int h, int v, logic [1:0] md, logic [15:0] sol, bit pol);
    out_t o;
    int x, y, idx;
    bit de;
    de = (h >= HS) && (h < HS + TH_ACT) && (v >= VS) && (v < VS + TV_ACT);
    x = de ? h - HS : 0;
    y = de ? v - VS : 0;
    o.hys = (h < TH_SYNC) ? pol : !pol;
    o.vys = (v < TV_SYNC) ? pol : !pol;
    o.de  = de;
    o.x   = X_W'(x);
    o.y   = Y_W'(y);
    o.fs  = (h == 0) && (v == 0);
    o.rgb = 16'h0000;
    if (de) begin
      case (md)
        2'd0: o.rgb = sol;
        2'd1: begin
          idx = x / BAR_W;
          if (idx > 7) idx = 7;
          o.rgb = BAR_TAB[idx];
        end
        2'd2: o.rgb = ((((x / CELL) + (y / CELL)) % 2) == 1) ? 16'hFFFF : 16'h0000;
        default: o.rgb = ((x % CELL == 0) || (y % CELL == 0)) ? 16'hFFFF : sol;
      endcase
    end
    return o;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_h = 0; m_v = 0; m_mode = 2'd0; m_solid = 16'h0000;
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      exp_q0.push_back(model_out(m_h, m_v, m_mode, m_solid, 1'b0));
      exp_q1.push_back(model_out(m_h, m_v, m_mode, m_solid, 1'b1));
      if (m_h == HT - 1 && m_v == VT - 1) begin
        m_mode = mode_r;
        m_solid = solid_r;
      end
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end
  end

  // scoreboard
  always @(negedge clk) begin
    out_t g0, g1, e0, e1;
    if (rst_n && exp_q0.size() > 0 && exp_q1.size() > 0) begin
      e0 = exp_q0.pop_front();
      e1 = exp_q1.pop_front();
      g0 = {vif0.hys, vif0.vys, vif0.de, vif0.pix_x, vif0.pix_y, vif0.frame_start, vif0.lcd_rgb};
      g1 = {vif1.hys, vif1.vys, vif1.de, vif1.pix_x, vif1.pix_y, vif1.frame_start, vif1.lcd_rgb};
      n_tests++;
      assert (g0 === e0) else begin
        n_fail++;
        $error("FAIL sb_pol0 got=%h exp=%h", g0, e0);
      end
      n_tests++;
      assert (g1 === e1) else begin
        n_fail++;
        $error("FAIL sb_pol1 got=%h exp=%h", g1, e1);
      end
    end
  end

  // driver tasks
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_frame();
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < F + 8) begin
      @(negedge clk);
      n++;
      seen = vif0.frame_start;
    end
    n_tests++;
    assert (seen) else begin
      n_fail++;
      $error("FAIL wait_frame got=timeout exp=frame_start");
    end
  endtask

  task automatic check_pix(input string tag, input int x, input int y, input logic [15:0] e);
    int n = 0;
    bit found = 1'b0;
    while (!found && n < 2 * F) begin
      @(negedge clk);
      n++;
      found = vif0.de && (int'(vif0.pix_x) == x) && (int'(vif0.pix_y) == y);
    end
    n_tests++;
    assert (found && vif0.lcd_rgb === e) else begin
      n_fail++;
      $error("FAIL %s got=%h found=%0d exp=%h", tag, vif0.lcd_rgb, found, e);
    end
  endtask

  task automatic apply(input logic [1:0] md, input logic [15:0] sol);
    mode_r = md;
    solid_r = sol;
    wait_frame();
  endtask

  initial begin
    int hl, vl, dl, fsn, first_de, fx, fy, n;
    bit found;
    hl = 0; vl = 0; dl = 0; fsn = 0; first_de = -1; fx = -1; fy = -1;

    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hys0", vif0.hys, 1);
    check("rst_vys0", vif0.vys, 1);
    check("rst_de0", vif0.de, 0);
    check("rst_fs0", vif0.frame_start, 0);
    check("rst_pix0", {vif0.pix_x, vif0.pix_y}, 0);
    check("rst_rgb0", vif0.lcd_rgb, 0);
    check("rst_hys1", vif1.hys, 0);
    check("rst_vys1", vif1.vys, 0);
    rst_n = 1'b1;

    // one full frame of mode-0 timing, latched solid colour still at reset value
    for (int i = 0; i < F; i++) begin
      @(negedge clk);
      if (!vif0.hys) hl++;
      if (!vif0.vys) vl++;
      if (vif0.de) dl++;
      if (vif0.frame_start) fsn++;
      if (vif0.de && first_de < 0) begin
        first_de = i;
        fx = int'(vif0.pix_x);
        fy = int'(vif0.pix_y);
      end
    end
    check("hys_low_cycles", hl, TH_SYNC * VT);
    check("vys_low_cycles", vl, TV_SYNC * HT);
    check("de_high_cycles", dl, TH_ACT * TV_ACT);
    check("frame_start_count", fsn, 1);
    check("first_de_cycle", first_de, VS * HT + HS);
    check("first_de_xy", {fx[15:0], fy[15:0]}, 0);

    repeat (10) @(negedge clk);
    apply(2'd1, 16'hF800);
    check_pix("bar_x0", 0, 0, 16'hFFFF);
    check_pix("bar_x9", 9, 0, 16'hFFFF);
    check_pix("bar_x10", 10, 0, 16'hFFE0);
    check_pix("bar_x50", 50, 1, 16'hF800);
    check_pix("bar_x69", 69, 1, 16'h001F);
    check_pix("bar_x70", 70, 2, 16'h0000);
    check_pix("bar_x83", 83, 2, 16'h0000);
    check_pix("bar_x20_y39", 20, 39, 16'h07FF);
    check_pix("bar_x30_y39", 30, 39, 16'h07E0);
    check_pix("bar_x40_y39", 40, 39, 16'hF81F);

    apply(2'd2, 16'hF800);
    check_pix("chk_0_0", 0, 0, 16'h0000);
    check_pix("chk_8_0", 8, 0, 16'hFFFF);
    check_pix("chk_15_7", 15, 7, 16'hFFFF);
    check_pix("chk_0_8", 0, 8, 16'hFFFF);
    check_pix("chk_8_8", 8, 8, 16'h0000);

    apply(2'd0, 16'hF800);
    check_pix("solid_5_5", 5, 5, 16'hF800);
    n = 0;
    found = 1'b0;
    while (!found && n < 2 * F) begin
      @(negedge clk);
      n++;
      found = vif0.de && (int'(vif0.pix_y) == 20);
    end
    check("reach_line20", found, 1);
    mode_r = 2'd3;
    solid_r = 16'h07E0;
    check_pix("switch_same_5_30", 5, 30, 16'hF800);
    check_pix("switch_same_0_35", 0, 35, 16'hF800);
    wait_frame();
    check_pix("grid_0_3", 0, 3, 16'hFFFF);
    check_pix("grid_5_5", 5, 5, 16'h07E0);
    check_pix("grid_3_8", 3, 8, 16'hFFFF);
    check_pix("grid_9_9", 9, 9, 16'h07E0);

    // reset in the middle of an active line
    check_pix("pre_reset_20_12", 20, 12, 16'h07E0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_hys0", vif0.hys, 1);
    check("mid_rst_vys0", vif0.vys, 1);
    check("mid_rst_de0", vif0.de, 0);
    check("mid_rst_rgb0", vif0.lcd_rgb, 0);
    check("mid_rst_hys1", vif1.hys, 0);
    check("mid_rst_vys1", vif1.vys, 0);
    check("mid_rst_de1", vif1.de, 0);
    check("mid_rst_rgb1", vif1.lcd_rgb, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_fs0", vif0.frame_start, 1);
    check("post_rst_fs1", vif1.frame_start, 1);
    check("post_rst_hys0", vif0.hys, 0);
    check("post_rst_hys1", vif1.hys, 1);
    check("post_rst_vys1", vif1.vys, 1);
    wait_frame();
    wait_frame();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Parametrised VGA timing and test-pattern generator.
- Successor to the fixed 640×480 solid-red VGA driver.
- Sits after the PLL on the pixel-clock domain and drives the VGA connector (hys, vys, lcd_rgb) directly.
- Adds programmable timing, sync polarity, data-enable, pixel coordinates, frame-start pulse, and four selectable patterns switched glitch-free at frame boundaries.

Parameters:
- H_SYNC, 96, horizontal sync width in pixel clocks
- H_BACK, 48, horizontal back porch
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vertical sync width in lines
- V_BACK, 33, vertical back porch in lines
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch in lines
- SYNC_POL, 0, 0 = sync pulses active-low, 1 = active-high
- CELL_LOG2, 5, log2 of checker/grid cell size in pixels (32)
- RGB_W, 16, colour width, RGB565 layout

Ports:
- clk  in  1  pixel clock (25 MHz at defaults)
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  pattern select: 0 solid, 1 colour bars, 2 checker, 3 grid
- solid_rgb  in  RGB_W  colour for solid mode and grid background
- hys  out  1  horizontal sync
- vys  out  1  vertical sync
- de  out  1  active-video enable
- pix_x  out  $clog2(H_ACTIVE)  x coordinate of current output pixel, 0 outside active
- pix_y  out  $clog2(V_ACTIVE)  y coordinate, 0 outside active
- frame_start  out  1  one-cycle pulse on the first clock of each frame
- lcd_rgb  out  RGB_W  pixel colour, 0 outside active

Behaviour:
- Derived constants:
  - H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT (800); V_TOTAL likewise (525).
  - H_START = H_SYNC+H_BACK (144); V_START = V_SYNC+V_BACK (35).
- Counters:
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments only on the h_cnt wrap, counts 0..V_TOTAL-1, and wraps to 0.
  - Region order within each axis is sync, back porch, active, front porch; sync occupies counts 0..SYNC-1.
- Sync and enable:
  - Sync is active when h_cnt < H_SYNC (respectively v_cnt < V_SYNC).
  - Output level is the sync term XOR ~SYNC_POL.
  - de = (H_START ≤ h_cnt < H_START+H_ACTIVE) AND (V_START ≤ v_cnt < V_START+V_ACTIVE).
- Latency:
  - Every output is registered and derived from the same counter state.
  - All outputs lag the counters by exactly one clock and are mutually aligned; no output leads another.
- Reset (async assert, sync release):
  - h_cnt = v_cnt = 0.
  - hys = vys = inactive level (1 when SYNC_POL = 0).
  - de = 0, pix_x = pix_y = 0, frame_start = 0, lcd_rgb = 0, latched mode = 0.
  - After reset, the first clock edge loads outputs for counter state (0,0), so frame_start = 1 on that edge.
  - Reset mid-frame aborts the frame; there is no partial-frame recovery.
- Mode latching:
  - mode and solid_rgb are sampled only when h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1.
  - Changes mid-frame take effect from the next frame's first pixel. No tearing.
- Patterns (evaluated only when de, otherwise lcd_rgb = 0):
  - Solid: lcd_rgb = latched solid_rgb.
  - Colour bars:
    - Eight bars, BAR_W = H_ACTIVE/8 (integer division).
    - Bar index comes from a counter that resets at line start and advances every BAR_W pixels, saturating at 7 (the last bar absorbs any remainder).
    - No divider in RTL.
    - Colours, in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Checker: pix_x[CELL_LOG2] XOR pix_y[CELL_LOG2]; 1 → FFFF, 0 → 0000.
  - Grid: FFFF where pix_x[CELL_LOG2-1:0] = 0 or pix_y[CELL_LOG2-1:0] = 0; otherwise latched solid_rgb.
- Coordinates: pix_x = h_cnt-H_START and pix_y = v_cnt-V_START during active; both held at 0 elsewhere.
- Width rules:
  - Counters are $clog2(H_TOTAL) and $clog2(V_TOTAL) bits.
  - All comparisons are unsigned; no overflow is possible by construction.

Decomposition:
- Shared package vga_pkg:
  - Mode encodings MODE_SOLID/MODE_BARS/MODE_CHECK/MODE_GRID.
  - The eight RGB565 bar colour constants.
  - Default 640×480 timing constants.
- One natural sub-module, vga_timing_core: counters, sync/de/coordinate generation and the frame-start strobe.
- The pattern mux and bar counter remain in the top module.

Test Plan:
- Defaults, mode 0, solid_rgb = F800:
  - hys low exactly 96 of every 800 clocks.
  - vys low exactly 1600 clocks per 420000-clock frame.
  - de high 640 clocks per line on 480 lines.
  - lcd_rgb = F800 whenever de is high, 0 otherwise.
- Alignment after reset release:
  - First de rise occurs on the output edge for (h,v) = (144,35), with pix_x = 0 and pix_y = 0.
  - frame_start pulses once per 420000 clocks.
- Mode 1 bars:
  - pix_x 0 → FFFF, 79 → FFFF, 80 → FFE0, 400 → F800, 639 → 0000, on every active line.
- Mode 2 checker: (x,y) = (0,0) → 0000, (32,0) → FFFF, (32,32) → 0000.
- Mode switch 0 → 3 at line 200 of a frame:
  - The rest of that frame stays solid.
  - Next frame shows grid: (0,y) = FFFF and (5,5) = solid_rgb.
- Reset mid-line and SYNC_POL = 1 build:
  - Asserting rst_n low immediately forces hys = vys = 0, de = 0, lcd_rgb = 0.
  - On release, timing restarts from (0,0) with frame_start = 1 and the sync pulse active-high.
